// File: rtl/ycc_pkg.sv
// Shared types, BT.601 full-range coefficients and the output clamp for the RGB to YCbCr pipeline.
package ycc_pkg;

    localparam int PIX_W      = 8;
    localparam int COEF_W     = 9;
    localparam int PROD_W     = 18;
    localparam int SUM_W      = 20;
    localparam int CNT_W      = 20;
    localparam int COEF_SHIFT = 8;

    localparam int C_OFFSET = 32896;
    localparam int C_ROUND  = 128;

    typedef logic [PIX_W-1:0]         pix_t;
    typedef logic signed [COEF_W-1:0] coef_t;

    typedef struct packed {
        pix_t r;
        pix_t g;
        pix_t b;
    } rgb_t;

    localparam coef_t C_YR  =  9'sd77;
    localparam coef_t C_YG  =  9'sd150;
    localparam coef_t C_YB  =  9'sd29;
    localparam coef_t C_CBR = -9'sd43;
    localparam coef_t C_CBG = -9'sd85;
    localparam coef_t C_CBB =  9'sd128;
    localparam coef_t C_CRR =  9'sd128;
    localparam coef_t C_CRG = -9'sd107;
    localparam coef_t C_CRB = -9'sd21;

    // Scale back by 2^COEF_SHIFT and saturate; Cb/Cr reach 256 for pure blue/red.
    function automatic pix_t clamp8(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] s;
        s = v >>> COEF_SHIFT;
        if (s[SUM_W-1])
            return '0;
        else if (s > SUM_W'(255))
            return '1;
        else
            return s[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/rgb2ycbcr_pipe_if.sv
// Pixel-in / component-out stream bundle of rgb2ycbcr_pipe; slave is the converter, master the source/sink.
interface rgb2ycbcr_pipe_if #(
    parameter int OUT_W = 32
);
    logic [7:0]       R_in;
    logic [7:0]       G_in;
    logic [7:0]       B_in;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] Y_O;
    logic [OUT_W-1:0] Cb_O;
    logic [OUT_W-1:0] Cr_O;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             frame_done;

    modport slave (
        input  R_in, G_in, B_in, in_valid, out_ready,
        output in_ready, Y_O, Cb_O, Cr_O, out_valid, out_last, frame_done
    );

    modport master (
        output R_in, G_in, B_in, in_valid, out_ready,
        input  in_ready, Y_O, Cb_O, Cr_O, out_valid, out_last, frame_done
    );
endinterface

// File: rtl/ycc_mac3.sv
// One colour component: three coefficient products (S2) then sum, offset, shift and clamp (S3).
// With RGB2YCC_LEVEL_SHIFT_EN the result register holds the clamped value minus 128 in two's complement.
module ycc_mac3
    import ycc_pkg::*;
#(
    parameter coef_t C0     = '0,
    parameter coef_t C1     = '0,
    parameter coef_t C2     = '0,
    parameter int    OFFSET = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en_s2,
    input  logic i_en_s3,
    input  pix_t i_a,
    input  pix_t i_b,
    input  pix_t i_c,
    output pix_t o_res
);

    logic signed [PROD_W-1:0] r_p0;
    logic signed [PROD_W-1:0] r_p1;
    logic signed [PROD_W-1:0] r_p2;
    logic signed [SUM_W-1:0]  w_sum;
    pix_t                     r_res;

    // NOTE: product registers only carry data qualified by the stage valids, so they need no reset.
    always_ff @(posedge clk) begin
        if (i_en_s2) begin
            r_p0 <= PROD_W'($signed({1'b0, i_a})) * PROD_W'(C0);
            r_p1 <= PROD_W'($signed({1'b0, i_b})) * PROD_W'(C1);
            r_p2 <= PROD_W'($signed({1'b0, i_c})) * PROD_W'(C2);
        end
    end

    assign w_sum = SUM_W'(r_p0) + SUM_W'(r_p1) + SUM_W'(r_p2) + SUM_W'(OFFSET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
        end else if (i_en_s3) begin
`ifdef RGB2YCC_LEVEL_SHIFT_EN
            r_res <= clamp8(w_sum) ^ 8'h80;
`else
            r_res <= clamp8(w_sum);
`endif
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/rgb2ycbcr_pipe.sv
// 3-stage RGB to full-range BT.601 YCbCr converter with global stall and per-frame pixel counting.
// Define RGB2YCC_LEVEL_SHIFT_EN for signed, level-shifted (-128..127) outputs.
module rgb2ycbcr_pipe
    import ycc_pkg::*;
#(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    rgb2ycbcr_pipe_if.slave  pix_if
);

    localparam int               FRAME_LEN = IMG_W * IMG_H;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);

    logic             r_v1;
    logic             r_v2;
    logic             r_v3;
    rgb_t             r_pix;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_done;

    logic w_adv;
    logic w_out_valid;
    logic w_out_fire;
    logic w_last;
    logic w_en_s2;
    logic w_en_s3;
    pix_t w_y;
    pix_t w_cb;
    pix_t w_cr;

    // The stall is global: every stage moves together, so bubbles stay in place.
    assign w_adv       = enable & (~r_v3 | pix_if.out_ready);
    assign w_out_valid = r_v3 & enable;
    assign w_out_fire  = w_out_valid & pix_if.out_ready;
    assign w_last      = (r_cnt == LAST_IDX);
    assign w_en_s2     = w_adv & r_v1;
    assign w_en_s3     = w_adv & r_v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (!enable) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= pix_if.in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv && pix_if.in_valid)
            r_pix <= '{r: pix_if.R_in, g: pix_if.G_in, b: pix_if.B_in};
    end

    // Counter wraps on the same edge that accepts the last pixel, so frames run back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (!enable) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_out_fire & w_last;
            if (w_out_fire)
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    ycc_mac3 #(.C0(C_YR),  .C1(C_YG),  .C2(C_YB),  .OFFSET(C_ROUND)) u_mac_y (
        .clk(clk), .rst_n(rst_n), .i_en_s2(w_en_s2), .i_en_s3(w_en_s3),
        .i_a(r_pix.r), .i_b(r_pix.g), .i_c(r_pix.b), .o_res(w_y)
    );

    ycc_mac3 #(.C0(C_CBR), .C1(C_CBG), .C2(C_CBB), .OFFSET(C_OFFSET)) u_mac_cb (
        .clk(clk), .rst_n(rst_n), .i_en_s2(w_en_s2), .i_en_s3(w_en_s3),
        .i_a(r_pix.r), .i_b(r_pix.g), .i_c(r_pix.b), .o_res(w_cb)
    );

    ycc_mac3 #(.C0(C_CRR), .C1(C_CRG), .C2(C_CRB), .OFFSET(C_OFFSET)) u_mac_cr (
        .clk(clk), .rst_n(rst_n), .i_en_s2(w_en_s2), .i_en_s3(w_en_s3),
        .i_a(r_pix.r), .i_b(r_pix.g), .i_c(r_pix.b), .o_res(w_cr)
    );

    assign pix_if.in_ready   = w_adv & rst_n;
    assign pix_if.out_valid  = w_out_valid;
    assign pix_if.out_last   = w_out_valid & w_last;
    assign pix_if.frame_done = r_frame_done;

`ifdef RGB2YCC_LEVEL_SHIFT_EN
    assign pix_if.Y_O  = {{(OUT_W-PIX_W){w_y[PIX_W-1]}},  w_y};
    assign pix_if.Cb_O = {{(OUT_W-PIX_W){w_cb[PIX_W-1]}}, w_cb};
    assign pix_if.Cr_O = {{(OUT_W-PIX_W){w_cr[PIX_W-1]}}, w_cr};
`else
    assign pix_if.Y_O  = {{(OUT_W-PIX_W){1'b0}}, w_y};
    assign pix_if.Cb_O = {{(OUT_W-PIX_W){1'b0}}, w_cb};
    assign pix_if.Cr_O = {{(OUT_W-PIX_W){1'b0}}, w_cr};
`endif

endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// Randomised bench for rgb2ycbcr_pipe (4x2 frames) against an arithmetic YCbCr model with a pixel queue.
module tb_rgb2ycbcr_pipe;

    localparam int FRAME = 8;

    typedef struct { logic [31:0] y, cb, cr; } ycc_t;
    typedef struct { logic [7:0] r, g, b; } rgb_tb_t;
    typedef struct {
        ycc_t obs;
        logic olast;
        ycc_t exp;
        bit   has_exp;
        bit   exp_last;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;

    int checks = 0;
    int failures = 0;

    ycc_t    exp_q[$];
    pair_t   pairs[$];
    rgb_tb_t tx_q[$];
    bit      last_fire_log[$];
    bit      fd_log[$];
    int      out_idx = 0;

    rgb2ycbcr_pipe_if #(.OUT_W(32)) bus();

    rgb2ycbcr_pipe #(.IMG_W(4), .IMG_H(2), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_if(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] exp_out(input int v);
`ifdef RGB2YCC_LEVEL_SHIFT_EN
        return 32'(v - 128);
`else
        return 32'(v);
`endif
    endfunction

    function automatic int sat(input int v);
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
    endfunction

    function automatic ycc_t ref_ycc(input int r, input int g, input int b);
        ycc_t e;
        e.y  = exp_out(sat((77*r + 150*g + 29*b + 128) / 256));
        e.cb = exp_out(sat((-43*r - 85*g + 128*b + 32896) / 256));
        e.cr = exp_out(sat((128*r - 107*g - 21*b + 32896) / 256));
        return e;
    endfunction

    // Inputs are set by the caller at the falling edge; records both handshakes of the coming rising edge.
    task automatic step(output bit acc);
        bit    fire;
        bit    el;
        pair_t p;
        #1;
        acc  = bus.in_valid && bus.in_ready;
        fire = bus.out_valid && bus.out_ready;
        el   = 1'b0;
        if (acc)
            exp_q.push_back(ref_ycc(bus.R_in, bus.G_in, bus.B_in));
        if (fire) begin
            p.obs     = '{bus.Y_O, bus.Cb_O, bus.Cr_O};
            p.olast   = bus.out_last;
            p.has_exp = (exp_q.size() > 0);
            p.exp     = p.has_exp ? exp_q.pop_front() : '{0, 0, 0};
            el        = (out_idx == FRAME - 1);
            p.exp_last = el;
            out_idx   = el ? 0 : out_idx + 1;
            pairs.push_back(p);
        end
        last_fire_log.push_back(fire && el);
        if (!enable) begin
            exp_q.delete();
            out_idx = 0;
        end
        @(posedge clk);
        @(negedge clk);
        fd_log.push_back(bus.frame_done);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        pairs.delete();
        tx_q.delete();
        last_fire_log.delete();
        fd_log.delete();
        out_idx = 0;
        rst_n = 1'b1;
    endtask

    task automatic run_stream(input int n_out);
        int budget = 0;
        bit acc;
        bus.out_ready = 1'b1;
        while (pairs.size() < n_out && budget < 400) begin
            if (tx_q.size() > 0) begin
                bus.in_valid = 1'b1;
                bus.R_in = tx_q[0].r;
                bus.G_in = tx_q[0].g;
                bus.B_in = tx_q[0].b;
            end else begin
                bus.in_valid = 1'b0;
            end
            step(acc);
            if (acc) void'(tx_q.pop_front());
            budget++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        bus.R_in = 8'd200; bus.G_in = 8'd10; bus.B_in = 8'd90;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_flags: valid=%b last=%b done=%b want 0 0 0", bus.out_valid, bus.out_last, bus.frame_done);
        end
        checks++;
        if (bus.Y_O !== 32'd0 || bus.Cb_O !== 32'd0 || bus.Cr_O !== 32'd0) begin
            failures++;
            $display("FAIL rst_data: got %h %h %h want 0 0 0", bus.Y_O, bus.Cb_O, bus.Cr_O);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        apply_reset();
        bus.R_in = 8'd255; bus.G_in = 8'd255; bus.B_in = 8'd255;
        bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL lat_in_ready: got %b want 1", bus.in_ready); end
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL lat_early1: out_valid %b want 0", bus.out_valid); end
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL lat_early2: out_valid %b want 0", bus.out_valid); end
        @(posedge clk); @(negedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL lat_third: out_valid %b want 1", bus.out_valid); end
        checks++;
        if (bus.Y_O !== exp_out(255) || bus.Cb_O !== exp_out(128) || bus.Cr_O !== exp_out(128)) begin
            failures++;
            $display("FAIL lat_white: got %h %h %h want %h %h %h", bus.Y_O, bus.Cb_O, bus.Cr_O,
                     exp_out(255), exp_out(128), exp_out(128));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.Y_O !== 32'd0 || bus.Cb_O !== 32'd0 || bus.Cr_O !== 32'd0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_async_rst: got %h %h %h v=%b want zeros", bus.Y_O, bus.Cb_O, bus.Cr_O, bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_primaries();
        int tbl[5][6] = '{'{255,255,255, 255,128,128}, '{255,0,0, 77,85,255}, '{0,0,255, 29,255,107},
                          '{0,0,0, 0,128,128}, '{0,255,0, 149,43,21}};
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 5; i++)
            tx_q.push_back('{8'(tbl[i][0]), 8'(tbl[i][1]), 8'(tbl[i][2])});
        for (int i = 0; i < 20; i++)
            tx_q.push_back('{8'($urandom), 8'($urandom), 8'($urandom)});
        run_stream(25);
        checks++;
        if (pairs.size() != 25) begin failures++; $display("FAIL prim_count: got %0d want 25", pairs.size()); end
        for (int i = 0; i < 5 && i < pairs.size(); i++) begin
            checks++;
            if (pairs[i].obs.y !== exp_out(tbl[i][3]) || pairs[i].obs.cb !== exp_out(tbl[i][4]) ||
                pairs[i].obs.cr !== exp_out(tbl[i][5])) begin
                failures++;
                $display("FAIL prim_const[%0d]: got %h %h %h want %h %h %h", i, pairs[i].obs.y, pairs[i].obs.cb,
                         pairs[i].obs.cr, exp_out(tbl[i][3]), exp_out(tbl[i][4]), exp_out(tbl[i][5]));
            end
        end
        foreach (pairs[i])
            if (!pairs[i].has_exp || pairs[i].obs != pairs[i].exp || pairs[i].olast !== pairs[i].exp_last) begin
                bad++;
                $display("FAIL prim_model[%0d]: got %h %h %h l=%b want %h %h %h l=%b", i, pairs[i].obs.y,
                         pairs[i].obs.cb, pairs[i].obs.cr, pairs[i].olast, pairs[i].exp.y, pairs[i].exp.cb,
                         pairs[i].exp.cr, pairs[i].exp_last);
            end
        checks++;
        if (bad != 0) failures++;
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        int sent = 0;
        int bad = 0;
        bit acc;
        apply_reset();
        for (int i = 0; i < 10; i++)
            tx_q.push_back('{8'(i * 25), 8'(255 - i * 13), 8'($urandom)});
        while (pairs.size() < 10 && cyc < 200) begin
            bus.out_ready = !(cyc >= 6 && cyc < 11);
            if (sent < 10) begin
                bus.in_valid = 1'b1;
                bus.R_in = tx_q[sent].r; bus.G_in = tx_q[sent].g; bus.B_in = tx_q[sent].b;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc >= 6 && cyc < 11) begin
                checks++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_stall_cyc%0d: in_ready=%b out_valid=%b want 0 1", cyc, bus.in_ready, bus.out_valid);
                end
                checks++;
                if (exp_q.size() == 0 || bus.Y_O !== exp_q[0].y || bus.Cb_O !== exp_q[0].cb || bus.Cr_O !== exp_q[0].cr) begin
                    failures++;
                    $display("FAIL bp_hold_cyc%0d: got %h %h %h, pending model queue size %0d", cyc, bus.Y_O,
                             bus.Cb_O, bus.Cr_O, exp_q.size());
                end
            end
            step(acc);
            if (acc) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (pairs.size() != 10 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_count: got %0d outputs, %0d left over, want 10 and 0", pairs.size(), exp_q.size());
        end
        foreach (pairs[i])
            if (!pairs[i].has_exp || pairs[i].obs != pairs[i].exp) begin
                bad++;
                $display("FAIL bp_order[%0d]: got %h %h %h want %h %h %h", i, pairs[i].obs.y, pairs[i].obs.cb,
                         pairs[i].obs.cr, pairs[i].exp.y, pairs[i].exp.cb, pairs[i].exp.cr);
            end
        checks++;
        if (bad != 0) failures++;
    endtask

    task automatic test_back_to_back_frames();
        int bad = 0;
        int pulses = 0;
        apply_reset();
        for (int i = 0; i < 17; i++)
            tx_q.push_back('{8'($urandom), 8'($urandom), 8'($urandom)});
        run_stream(17);
        repeat (2) begin bit a; step(a); end
        checks++;
        if (pairs.size() != 17) begin failures++; $display("FAIL frame_count: got %0d want 17", pairs.size()); end
        foreach (pairs[i])
            if (!pairs[i].has_exp || pairs[i].obs != pairs[i].exp || pairs[i].olast !== ((i % FRAME) == FRAME - 1)) begin
                bad++;
                $display("FAIL frame_out[%0d]: got %h %h %h last=%b want %h %h %h last=%b", i, pairs[i].obs.y,
                         pairs[i].obs.cb, pairs[i].obs.cr, pairs[i].olast, pairs[i].exp.y, pairs[i].exp.cb,
                         pairs[i].exp.cr, ((i % FRAME) == FRAME - 1));
            end
        checks++;
        if (bad != 0) failures++;
        bad = 0;
        foreach (fd_log[c]) begin
            pulses += fd_log[c];
            if (fd_log[c] !== last_fire_log[c]) bad++;
        end
        checks++;
        if (bad != 0 || pulses != 2) begin
            failures++;
            $display("FAIL frame_done: %0d misplaced cycles, %0d pulses, want 0 misplaced and 2 pulses", bad, pulses);
        end
    endtask

    task automatic test_abort();
        int cyc = 0;
        int abort_at = -1;
        int bad = 0;
        bit acc;
        apply_reset();
        bus.R_in = 8'($urandom); bus.G_in = 8'($urandom); bus.B_in = 8'($urandom);
        while (cyc < 200 && !(abort_at >= 0 && pairs.size() >= 13)) begin
            if (abort_at < 0 && pairs.size() >= 3) begin
                abort_at = cyc;
                enable = 1'b0;
            end else begin
                enable = 1'b1;
            end
            bus.in_valid = 1'b1;
            #1;
            if (cyc == abort_at) begin
                checks++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_gate: in_ready=%b out_valid=%b want 0 0", bus.in_ready, bus.out_valid);
                end
            end
            step(acc);
            if (acc) begin
                bus.R_in = 8'($urandom); bus.G_in = 8'($urandom); bus.B_in = 8'($urandom);
            end
            cyc++;
        end
        enable = 1'b1;
        bus.in_valid = 1'b0;
        checks++;
        if (pairs.size() != 13) begin failures++; $display("FAIL abort_count: got %0d want 13", pairs.size()); end
        foreach (pairs[i])
            if (!pairs[i].has_exp || pairs[i].obs != pairs[i].exp || pairs[i].olast !== (i == 10)) begin
                bad++;
                $display("FAIL abort_out[%0d]: got %h %h %h last=%b want %h %h %h last=%b", i, pairs[i].obs.y,
                         pairs[i].obs.cb, pairs[i].obs.cr, pairs[i].olast, pairs[i].exp.y, pairs[i].exp.cb,
                         pairs[i].exp.cr, (i == 10));
            end
        checks++;
        if (bad != 0) failures++;
        bad = 0;
        foreach (fd_log[c])
            if (fd_log[c] !== last_fire_log[c]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL abort_frame_done: %0d misplaced cycles want 0", bad); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.R_in = '0; bus.G_in = '0; bus.B_in = '0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_primaries();
        test_backpressure();
        test_back_to_back_frames();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb2ycbcr_pipe.md
Name: rgb2ycbcr_pipe

Overview:
Pixel-stream colour converter that sits directly upstream of the YCbCr frame buffer. It accepts 8-bit RGB pixels under a valid/ready handshake and converts them to full-range BT.601 (JPEG) Y/Cb/Cr through a 3-stage pipeline. Its 32-bit zero-extended component outputs and out_valid drive the buffer's Y_in/Cb_in/Cr_in and en_write directly. It counts delivered pixels and marks the last pixel of each frame.

Parameters:
IMG_W, 512, pixels per line
IMG_H, 512, lines per frame; frame length = IMG_W*IMG_H, must be 1..2^20
OUT_W, 32, output component width; values are zero- or sign-extended to this width

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  synchronous run enable; low = flush and hold
R_in  input  8  red component
G_in  input  8  green component
B_in  input  8  blue component
in_valid  input  1  input pixel valid
in_ready  output  1  block can accept a pixel this cycle
Y_O  output  OUT_W  luma
Cb_O  output  OUT_W  blue-difference chroma
Cr_O  output  OUT_W  red-difference chroma
out_valid  output  1  Y_O/Cb_O/Cr_O valid (drives en_write)
out_ready  input  1  downstream accepts; tie high if the sink never stalls
out_last  output  1  high with the final pixel of a frame
frame_done  output  1  one-cycle pulse when the final pixel is accepted

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids 0, pixel counter 0, Y_O/Cb_O/Cr_O 0, out_valid/out_last/frame_done 0. in_ready is 0 while rst_n is low.
- enable low (synchronous): clear stage valids and counter; in_ready=0; out_valid=0. Data registers hold their values.
- Pipeline advance: adv = enable & (~v3 | out_ready); in_ready = adv. On adv, every stage shifts. Stall is global, so bubbles are not compressed.
- Pixel accepted = in_valid & in_ready. Latency is exactly 3 cycles with no stall: a pixel accepted at edge N gives out_valid at edge N+3.
- S1: register R, G, B. S2: nine signed products with 18-bit signed intermediates. S3: sum, add offset and rounding, arithmetic shift right by 8, clamp.
- Y = (77R + 150G + 29B + 128) >> 8
- Cb = (-43R - 85G + 128B + 32896) >> 8
- Cr = (128R - 107G - 21B + 32896) >> 8
- Clamp each result to 0..255. The Cb and Cr sums can reach 256 (e.g. pure blue or pure red), so the clamp is mandatory.
- Outputs are zero-extended to OUT_W. Output registers change only on adv with v2=1, so they hold while stalled.
- Counter (20 bits) increments on out_valid & out_ready.
- out_last = out_valid & (counter == IMG_W*IMG_H-1).
- frame_done is registered: it pulses the cycle after the last pixel is accepted. The counter wraps to 0 on that same edge.
- Frame-boundary edge case: an accept of the last pixel and a new input accept in the same cycle are both legal. No bubble is inserted between frames.
- Reset or enable-low mid-frame discards in-flight pixels. The counter restarts at 0, so the next accepted output is pixel 0.

Optional Feature:
RGB2YCC_LEVEL_SHIFT_EN
- Defined: Y_O = Y-128, Cb_O = Cb-128, Cr_O = Cr-128, each sign-extended to OUT_W (two's complement, range -128..127), ready for a DCT stage. Clamping happens before the subtraction.
- Undefined: unsigned 0..255 outputs, zero-extended.
- Latency is unchanged in both cases.

Decomposition:
- Package ycc_pkg holds:
  - coefficient localparams (77, 150, 29, -43, -85, 128, -107, -21)
  - C_OFFSET=32896 and C_ROUND=128
  - COEF_SHIFT=8
  - PIX_W=8
  - a clamp8 function
- One natural sub-module: ycc_mac3. It takes three 8-bit unsigned inputs and three signed coefficients and returns a clamped 8-bit result, registered over S2/S3. It is instantiated three times, once each for Y, Cb and Cr.

Test Plan:
- Reset/latency: drive RGB=(255,255,255) with out_ready=1 -> out_valid exactly 3 cycles later with Y=255, Cb=128, Cr=128; after rst_n pulse, all outputs are 0.
- Primaries: red (255,0,0) -> Y=77, Cb=85, Cr=255 (clamped from 256); blue (0,0,255) -> Y=29, Cb=255 (clamped), Cr=107; black -> 0/128/128.
- Backpressure: stream 10 distinct pixels and hold out_ready low for 5 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, no pixel lost or duplicated, order preserved.
- Frame boundary: with IMG_W=4 and IMG_H=2, stream 17 pixels back-to-back -> out_last on the 8th and 16th outputs, frame_done pulses one cycle after each, 17th output is counted as pixel 0.
- Mid-frame abort: drop enable for 1 cycle after 3 outputs -> pipeline flushed, next accepted output has counter 0, and out_last arrives only after 8 further outputs.
- RGB2YCC_LEVEL_SHIFT_EN build: white -> Y_O=127, Cb_O=0, Cr_O=0; black -> Y_O=32'hFFFFFF80 (-128), Cb_O=0, Cr_O=0.
